ex_cond_stage: RTL and testbench
================================

Name: ex_cond_stage

Overview:
- Execute-stage condition and flag unit plus EX/MEM pipeline register.
- Consumes the ALU result and the {N,Z,C,V} flags produced in EX, and holds the architectural NZCV flag register.
- Evaluates the instruction's 4-bit ARM condition field and gates its side effects (register write, memory write, PC write).
- Registers the surviving controls and data into the MEM stage under stall/flush control.

Parameters:
- DW, 32, datapath width of ALU result and store data.
- RW, 4, register-address width (WA3).

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- ValidE  in  1  EX holds a real instruction (0 = bubble)
- StallE  in  1  EX instruction is held this cycle; no flag update
- StallM  in  1  hold EX/MEM register
- FlushM  in  1  insert bubble into MEM
- CondE  in  4  ARM condition field
- ALUFlags  in  4  {N,Z,C,V} from ALU this cycle
- FlagWriteE  in  2  [1]=write N,Z; [0]=write C,V
- RegWriteE, MemWriteE, MemtoRegE, PCSrcE, BranchE  in  1 each  decoded controls
- ALUResultE  in  DW  ALU result
- WriteDataE  in  DW  store data
- WA3E  in  RW  destination register
- CondExE  out  1  condition passed AND ValidE (combinational)
- BranchTakenE  out  1  CondExE & BranchE (combinational, to fetch redirect/hazard unit)
- FlagsQ  out  4  current architectural NZCV
- RegWriteM, MemWriteM, MemtoRegM, PCSrcM  out  1 each  registered gated controls
- ALUResultM, WriteDataM  out  DW  registered data
- WA3M  out  RW  registered destination

Behaviour:
- Reset (async, immediate): FlagsQ=4'b0000; all M-stage outputs 0.
- Condition decode uses FlagsQ, not ALUFlags:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1
  - F: treated as AL; no fault.
- CondExE = condpass & ValidE.
- Flag update at rising edge when CondExE & ~StallE:
  - FlagWriteE[1] writes FlagsQ[3:2] <= ALUFlags[3:2].
  - FlagWriteE[0] writes FlagsQ[1:0] <= ALUFlags[1:0].
  - Each half is independent; otherwise FlagsQ holds.
- Flag latency: the next instruction entering EX sees the updated flags (1 cycle); no bypass is required.
- Stalled EX instruction: flags are never written while StallE=1, so re-evaluation of the same instruction sees unchanged flags.
- EX/MEM register, priority FlushM > StallM > load:
  - FlushM=1: RegWriteM, MemWriteM, MemtoRegM, PCSrcM <= 0; data/WA3M don't-care but cleared to 0.
  - StallM=1 (no flush): all M outputs hold.
  - Otherwise: RegWriteM <= RegWriteE & CondExE; MemWriteM <= MemWriteE & CondExE; PCSrcM <= PCSrcE & CondExE; MemtoRegM <= MemtoRegE & ValidE; data and WA3 load unconditionally.
- Failed condition: the instruction still flows into MEM as a harmless bubble with all write enables 0.
- Reset mid-operation: flags and M register clear immediately; no partial update survives.

Optional Feature:
- Macro: EX_COND_STATS_EN.
- When defined: adds outputs ExecCount[31:0] and SquashCount[31:0], both reset to 0.
  - Gated on ValidE & ~StallE: ExecCount increments when CondExE=1; SquashCount increments when CondExE=0.
  - Both counters wrap modulo 2^32.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - cond-code localparams (COND_EQ..COND_AL).
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
  - FlagWrite bit positions.
- One sub-module: cond_check, purely combinational (Cond, Flags -> condpass).
- The flag register and the EX/MEM register stay in the top module.

Test Plan:
- Reset asserted mid-cycle with FlagsQ=4'b1111 -> FlagsQ=0 and RegWriteM=0 immediately, without waiting for clk.
- CMP setting Z: ALUFlags=4'b0110, FlagWriteE=2'b11, CondE=E. Next instr CondE=0 (EQ) with RegWriteE=1 -> CondExE=1; RegWriteM=1 one cycle later.
- Partial write: FlagsQ=4'b0011, FlagWriteE=2'b10, ALUFlags=4'b1000 -> FlagsQ=4'b1011.
- Failed conditional store: FlagsQ Z=0, CondE=0 (EQ), MemWriteE=1, FlagWriteE=2'b11 -> MemWriteM=0, FlagsQ unchanged, BranchTakenE=0.
- Stall/flush: StallE=1 with flag-setting AL instr -> FlagsQ unchanged. StallM=1 holds ALUResultM=32'hDEADBEEF. Simultaneous FlushM=1 & StallM=1 -> all M write enables 0.
- Signed compares with N=1,V=0 -> GE fails, LT passes, GT fails, LE passes. With EX_COND_STATS_EN defined, after 3 executed + 2 squashed -> ExecCount=3, SquashCount=2.

Source files
------------

// File: rtl/ex_cond_stage_pkg.sv
// Shared constants for the EX condition/flag stage: ARM condition codes,
// NZCV bit positions and FlagWrite bit positions.
package ex_cond_stage_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/ex_cond_stage_cond_check.sv
// Combinational ARM condition-field evaluator against the architectural NZCV.
module cond_check
  import ex_cond_stage_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondPass
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    CondPass = 1'b1;
    case (Cond)
      COND_EQ: CondPass = z;
      COND_NE: CondPass = ~z;
      COND_CS: CondPass = c;
      COND_CC: CondPass = ~c;
      COND_MI: CondPass = n;
      COND_PL: CondPass = ~n;
      COND_VS: CondPass = v;
      COND_VC: CondPass = ~v;
      COND_HI: CondPass = c & ~z;
      COND_LS: CondPass = ~c | z;
      COND_GE: CondPass = (n == v);
      COND_LT: CondPass = (n != v);
      COND_GT: CondPass = ~z & (n == v);
      COND_LE: CondPass = z | (n != v);
      // AL and the unused 4'hF encoding both execute unconditionally
      default: CondPass = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_cond_stage.sv
// Execute-stage condition/flag unit with NZCV register and EX/MEM pipeline register.
// Optional EX_COND_STATS_EN adds executed/squashed instruction counters.
module ex_cond_stage
  import ex_cond_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ValidE,
  input  logic          StallE,
  input  logic          StallM,
  input  logic          FlushM,
  input  logic [3:0]    CondE,
  input  logic [3:0]    ALUFlags,
  input  logic [1:0]    FlagWriteE,
  input  logic          RegWriteE,
  input  logic          MemWriteE,
  input  logic          MemtoRegE,
  input  logic          PCSrcE,
  input  logic          BranchE,
  input  logic [DW-1:0] ALUResultE,
  input  logic [DW-1:0] WriteDataE,
  input  logic [RW-1:0] WA3E,
  output logic          CondExE,
  output logic          BranchTakenE,
  output logic [3:0]    FlagsQ,
  output logic          RegWriteM,
  output logic          MemWriteM,
  output logic          MemtoRegM,
  output logic          PCSrcM,
  output logic [DW-1:0] ALUResultM,
  output logic [DW-1:0] WriteDataM,
`ifdef EX_COND_STATS_EN
  output logic [31:0]   ExecCount,
  output logic [31:0]   SquashCount,
`endif
  output logic [RW-1:0] WA3M
);

  logic cond_pass;
  logic flag_en;

  cond_check u_cond_check (
    .Cond     (CondE),
    .Flags    (FlagsQ),
    .CondPass (cond_pass)
  );

  assign CondExE      = cond_pass & ValidE;
  assign BranchTakenE = CondExE & BranchE;
  // A stalled instruction is re-evaluated next cycle, so it must not touch flags yet
  assign flag_en      = CondExE & ~StallE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      FlagsQ <= 4'b0000;
    end else begin
      if (flag_en & FlagWriteE[FW_NZ]) begin
        FlagsQ[FLAG_N] <= ALUFlags[FLAG_N];
        FlagsQ[FLAG_Z] <= ALUFlags[FLAG_Z];
      end
      if (flag_en & FlagWriteE[FW_CV]) begin
        FlagsQ[FLAG_C] <= ALUFlags[FLAG_C];
        FlagsQ[FLAG_V] <= ALUFlags[FLAG_V];
      end
    end
  end

  // Flush beats stall; a failed condition still loads, but as a bubble with no write enables
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      PCSrcM     <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      WA3M       <= '0;
    end else if (FlushM) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      PCSrcM     <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      WA3M       <= '0;
    end else if (!StallM) begin
      RegWriteM  <= RegWriteE & CondExE;
      MemWriteM  <= MemWriteE & CondExE;
      MemtoRegM  <= MemtoRegE & ValidE;
      PCSrcM     <= PCSrcE & CondExE;
      ALUResultM <= ALUResultE;
      WriteDataM <= WriteDataE;
      WA3M       <= WA3E;
    end
  end

`ifdef EX_COND_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ExecCount   <= '0;
      SquashCount <= '0;
    end else if (ValidE & ~StallE) begin
      if (CondExE) ExecCount <= ExecCount + 32'd1;
      else         SquashCount <= SquashCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_cond_stage.sv
// Self-checking bench for ex_cond_stage: flag/condition model plus an expected
// queue of EX/MEM register contents, compared one entry per clock.
module tb_ex_cond_stage;

  localparam int DW = 32;
  localparam int RW = 4;
  localparam int W  = 4 + 2 * DW + RW;

  logic          clk = 1'b0;
  logic          reset;
  logic          ValidE, StallE, StallM, FlushM;
  logic [3:0]    CondE, ALUFlags;
  logic [1:0]    FlagWriteE;
  logic          RegWriteE, MemWriteE, MemtoRegE, PCSrcE, BranchE;
  logic [DW-1:0] ALUResultE, WriteDataE;
  logic [RW-1:0] WA3E;
  logic          CondExE, BranchTakenE;
  logic [3:0]    FlagsQ;
  logic          RegWriteM, MemWriteM, MemtoRegM, PCSrcM;
  logic [DW-1:0] ALUResultM, WriteDataM;
  logic [RW-1:0] WA3M;
`ifdef EX_COND_STATS_EN
  logic [31:0]   ExecCount, SquashCount;
  logic [31:0]   exec_m, squash_m;
`endif

  ex_cond_stage #(.DW(DW), .RW(RW)) dut (
    .clk          (clk),
    .reset        (reset),
    .ValidE       (ValidE),
    .StallE       (StallE),
    .StallM       (StallM),
    .FlushM       (FlushM),
    .CondE        (CondE),
    .ALUFlags     (ALUFlags),
    .FlagWriteE   (FlagWriteE),
    .RegWriteE    (RegWriteE),
    .MemWriteE    (MemWriteE),
    .MemtoRegE    (MemtoRegE),
    .PCSrcE       (PCSrcE),
    .BranchE      (BranchE),
    .ALUResultE   (ALUResultE),
    .WriteDataE   (WriteDataE),
    .WA3E         (WA3E),
    .CondExE      (CondExE),
    .BranchTakenE (BranchTakenE),
    .FlagsQ       (FlagsQ),
    .RegWriteM    (RegWriteM),
    .MemWriteM    (MemWriteM),
    .MemtoRegM    (MemtoRegM),
    .PCSrcM       (PCSrcM),
    .ALUResultM   (ALUResultM),
    .WriteDataM   (WriteDataM),
`ifdef EX_COND_STATS_EN
    .ExecCount    (ExecCount),
    .SquashCount  (SquashCount),
`endif
    .WA3M         (WA3M)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_model;
  logic [W-1:0] m_act;
  logic [W-1:0] exp_m;
  logic [3:0]   flags_m;
  logic         exp_cex, exp_bt;
  int           checks = 0;
  int           errors = 0;

  assign m_act = {RegWriteM, MemWriteM, MemtoRegM, PCSrcM, ALUResultM, WriteDataM, WA3M};

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Applies one cycle of stimulus at the falling edge and pushes the EX/MEM
  // contents expected after the following rising edge.
  task automatic drive(input logic v, se, sm, fm, input logic [3:0] c, af,
                       input logic [1:0] fw, input logic rw, mw, mr, pc, br,
                       input logic [DW-1:0] ar, wd, input logic [RW-1:0] wa);
    @(negedge clk);
    ValidE = v; StallE = se; StallM = sm; FlushM = fm;
    CondE = c; ALUFlags = af; FlagWriteE = fw;
    RegWriteE = rw; MemWriteE = mw; MemtoRegE = mr; PCSrcE = pc; BranchE = br;
    ALUResultE = ar; WriteDataE = wd; WA3E = wa;
    exp_cex = cond_ok(c, flags_m) & v;
    exp_bt  = exp_cex & br;
    if (fm) m_model = '0;
    else if (!sm) m_model = {rw & exp_cex, mw & exp_cex, mr & v, pc & exp_cex, ar, wd, wa};
    exp_q.push_back(m_model);
    if (exp_cex && !se) begin
      if (fw[1]) flags_m[3:2] = af[3:2];
      if (fw[0]) flags_m[1:0] = af[1:0];
    end
`ifdef EX_COND_STATS_EN
    if (v && !se) begin
      if (exp_cex) exec_m = exec_m + 1;
      else squash_m = squash_m + 1;
    end
`endif
  endtask

  task automatic model_reset();
    flags_m = 4'b0;
    m_model = '0;
    exp_q.delete();
`ifdef EX_COND_STATS_EN
    exec_m = 0;
    squash_m = 0;
`endif
  endtask

  task automatic idle_inputs();
    ValidE = 0; StallE = 0; StallM = 0; FlushM = 0;
    CondE = 4'hE; ALUFlags = 0; FlagWriteE = 0;
    RegWriteE = 0; MemWriteE = 0; MemtoRegE = 0; PCSrcE = 0; BranchE = 0;
    ALUResultE = 0; WriteDataE = 0; WA3E = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (FlagsQ !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", FlagsQ); end
    checks++;
    if (m_act !== '0) begin errors++; $display("FAIL reset_m got=%h exp=0", m_act); end
    reset = 1'b0;

    // Load flags=1111 and a live RegWriteM, then reset between clock edges
    drive(1, 0, 0, 0, 4'hE, 4'b1111, 2'b11, 1, 0, 0, 0, 0, 32'h1234, 32'h0, 4'd3);
    @(posedge clk); #1;
    exp_m = exp_q.pop_front();
    checks++;
    if (FlagsQ !== 4'b1111 || m_act !== exp_m) begin
      errors++; $display("FAIL pre_reset flags=%b m=%h exp flags=1111 m=%h", FlagsQ, m_act, exp_m);
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (FlagsQ !== 4'b0000 || RegWriteM !== 1'b0 || m_act !== '0) begin
      errors++; $display("FAIL async_reset flags=%b regwrite=%b m=%h exp 0000/0/0", FlagsQ, RegWriteM, m_act);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_cmp_eq();
    drive(1, 0, 0, 0, 4'hE, 4'b0110, 2'b11, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
    @(posedge clk); #1;
    exp_m = exp_q.pop_front();
    checks++;
    if (FlagsQ !== flags_m || m_act !== exp_m) begin
      errors++; $display("FAIL cmp_flags flags=%b exp=%b m=%h exp=%h", FlagsQ, flags_m, m_act, exp_m);
    end
    drive(1, 0, 0, 0, 4'h0, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 32'hA5A5, 32'h0, 4'd7);
    #1;
    checks++;
    if (CondExE !== 1'b1) begin errors++; $display("FAIL eq_condex got=%b exp=1", CondExE); end
    @(posedge clk); #1;
    exp_m = exp_q.pop_front();
    checks++;
    if (m_act !== exp_m || RegWriteM !== 1'b1) begin
      errors++; $display("FAIL eq_regwrite m=%h exp=%h", m_act, exp_m);
    end
  endtask

  task automatic test_partial_write();
    drive(1, 0, 0, 0, 4'hE, 4'b0011, 2'b11, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    drive(1, 0, 0, 0, 4'hE, 4'b1000, 2'b10, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
    @(posedge clk); #1;
    exp_m = exp_q.pop_front();
    checks++;
    if (FlagsQ !== 4'b1011 || FlagsQ !== flags_m) begin
      errors++; $display("FAIL partial_write flags=%b exp=1011", FlagsQ);
    end
  endtask

  task automatic test_failed_store();
    // Flags are 1011 here: Z=0, so EQ fails
    drive(1, 0, 0, 0, 4'h0, 4'b0100, 2'b11, 0, 1, 0, 0, 1, 32'h40, 32'hCAFE, 4'd2);
    #1;
    checks++;
    if (CondExE !== 1'b0 || BranchTakenE !== 1'b0) begin
      errors++; $display("FAIL fail_store_comb condex=%b bt=%b exp 0/0", CondExE, BranchTakenE);
    end
    @(posedge clk); #1;
    exp_m = exp_q.pop_front();
    checks++;
    if (m_act !== exp_m || MemWriteM !== 1'b0 || FlagsQ !== 4'b1011) begin
      errors++; $display("FAIL fail_store m=%h exp=%h flags=%b exp=1011", m_act, exp_m, FlagsQ);
    end
  endtask

  task automatic test_stall_flush();
    drive(1, 1, 0, 0, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    checks++;
    if (FlagsQ !== 4'b1011) begin errors++; $display("FAIL stalle_flags got=%b exp=1011", FlagsQ); end
    drive(1, 0, 0, 0, 4'h1, 4'b0000, 2'b00, 1, 0, 1, 0, 0, 32'hDEADBEEF, 32'h11, 4'd9);
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    drive(1, 0, 1, 0, 4'hE, 4'b0000, 2'b00, 0, 1, 0, 1, 0, 32'h0BAD0BAD, 32'h22, 4'd1);
    @(posedge clk); #1;
    exp_m = exp_q.pop_front();
    checks++;
    if (ALUResultM !== 32'hDEADBEEF || m_act !== exp_m) begin
      errors++; $display("FAIL stallm_hold alu=%h exp=deadbeef m=%h exp=%h", ALUResultM, m_act, exp_m);
    end
    drive(1, 0, 1, 1, 4'hE, 4'b0000, 2'b00, 1, 1, 1, 1, 0, 32'h5, 32'h6, 4'd7);
    @(posedge clk); #1;
    exp_m = exp_q.pop_front();
    checks++;
    if ({RegWriteM, MemWriteM, MemtoRegM, PCSrcM} !== 4'b0000 || m_act !== exp_m) begin
      errors++; $display("FAIL flush_over_stall m=%h exp=%h", m_act, exp_m);
    end
  endtask

  task automatic test_signed();
    logic [3:0] conds [4];
    logic       want  [4];
    conds = '{4'hA, 4'hB, 4'hC, 4'hD};
    want  = '{1'b0, 1'b1, 1'b0, 1'b1};
    drive(1, 0, 0, 0, 4'hE, 4'b1000, 2'b11, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, conds[i], 4'b0000, 2'b00, 1, 0, 0, 0, 1, 32'(i), 32'h0, 4'(i));
      #1;
      checks++;
      if (CondExE !== want[i] || BranchTakenE !== want[i]) begin
        errors++; $display("FAIL signed_cond%0h condex=%b bt=%b exp=%b", conds[i], CondExE, BranchTakenE, want[i]);
      end
      @(posedge clk); #1;
      exp_m = exp_q.pop_front();
      checks++;
      if (m_act !== exp_m) begin errors++; $display("FAIL signed_m%0h got=%h exp=%h", conds[i], m_act, exp_m); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 8) == 0),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            32'($urandom), 32'($urandom), 4'($urandom_range(0, 15)));
      #1;
      checks++;
      if (CondExE !== exp_cex || BranchTakenE !== exp_bt) begin
        errors++; $display("FAIL rand_comb[%0d] condex=%b bt=%b exp %b/%b", i, CondExE, BranchTakenE, exp_cex, exp_bt);
      end
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        checks++; errors++; $display("FAIL rand_queue[%0d] got=empty exp=entry", i);
      end else begin
        exp_m = exp_q.pop_front();
        checks++;
        if (m_act !== exp_m || FlagsQ !== flags_m) begin
          errors++; $display("FAIL rand_seq[%0d] m=%h exp=%h flags=%b exp=%b", i, m_act, exp_m, FlagsQ, flags_m);
        end
      end
    end
  endtask

`ifdef EX_COND_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
    drive(1, 1, 0, 0, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
    for (int i = 0; i < 2; i++) drive(1, 0, 0, 0, 4'h0, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
    drive(0, 0, 0, 0, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
    @(posedge clk); #1;
    exp_q.delete();
    checks++;
    if (ExecCount !== 32'd3 || ExecCount !== exec_m) begin
      errors++; $display("FAIL exec_count got=%0d exp=3", ExecCount);
    end
    checks++;
    if (SquashCount !== 32'd2 || SquashCount !== squash_m) begin
      errors++; $display("FAIL squash_count got=%0d exp=2", SquashCount);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_cmp_eq();
    test_partial_write();
    test_failed_store();
    test_stall_flush();
    test_signed();
    test_back_to_back();
`ifdef EX_COND_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
